// File: rtl/sram_march_bist.sv
// March C- BIST engine driving NCH single-port SRAMs in lockstep.
// Latency: 10*DEPTH access cycles, one drain cycle for the final compare, one done cycle.
// Backpressure: none; RAMs are assumed ready every cycle, start is only honoured in IDLE.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bist_start, bg_sel   start level (sampled in IDLE), background select (0 solid, 1 checkerboard)
//   bist_busy/done/fail  status: busy during RUN+DRAIN, one-cycle done pulse, sticky fail
//   fail_addr/elem/ch    first-miscompare address, March element and channel mask
//   fail_cnt             saturating count of failing read cycles
//   ram_cen/wen/a/d      registered RAM controls shared by all channels (active-low enables)
//   ram_q                read data, channel c at [c*DW +: DW], valid one cycle after a read
module sram_march_bist #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 1024,
  parameter int NCH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bist_start,
  input  logic              bg_sel,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [AW-1:0]     fail_addr,
  output logic [2:0]        fail_elem,
  output logic [NCH-1:0]    fail_ch,
  output logic [15:0]       fail_cnt,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [AW-1:0]     ram_a,
  output logic [DW-1:0]     ram_d,
  input  logic [NCH*DW-1:0] ram_q
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] CHECKER   = {(DW/2){2'b01}};

  state_t        state, state_nxt;
  // elem/addr/phase describe the access currently presented on the RAM pins.
  logic [2:0]    elem, elem_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic          phase, phase_nxt;
  logic          bg;

  logic          start_acc;
  logic          two_phase;
  logic          descending;
  logic          at_last;
  logic          acc_run;
  logic          acc_we;
  logic          acc_inv;
  logic [DW-1:0] acc_bg;

  // Compare pipeline: one stage behind the read that was issued.
  logic          exp_vld;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] exp_addr;
  logic [2:0]    exp_elem;
  logic [NCH-1:0] mism;

  // ---------------------------------------------------------------------------
  // Sequencer: next access and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    elem_nxt   = elem;
    addr_nxt   = addr;
    phase_nxt  = phase;
    start_acc  = 1'b0;
    two_phase  = (elem >= 3'd1) && (elem <= 3'd4);
    descending = (elem == 3'd3) || (elem == 3'd4);
    at_last    = descending ? (addr == '0) : (addr == LAST_ADDR);

    case (state)
      S_IDLE: begin
        if (bist_start) begin
          start_acc = 1'b1;
          state_nxt = S_RUN;
          elem_nxt  = 3'd0;
          addr_nxt  = '0;
          phase_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (two_phase && !phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (at_last) begin
            if (elem == 3'd5) begin
              state_nxt = S_DRAIN;
            end else begin
              elem_nxt = elem + 3'd1;
              // Elements entered from M2/M3 (i.e. M3/M4) walk downwards.
              addr_nxt = ((elem == 3'd2) || (elem == 3'd3)) ? LAST_ADDR : '0;
            end
          end else begin
            addr_nxt = descending ? (addr - 1'b1) : (addr + 1'b1);
          end
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decode of the access about to be driven. The background comes straight
  // from bg_sel on the start cycle because bg is only latched at that edge.
  always_comb begin
    acc_run = (state_nxt == S_RUN);
    acc_we  = (elem_nxt == 3'd0) || phase_nxt;
    // Writes of ~B in M1/M3; reads of ~B in M2/M4.
    acc_inv = acc_we ? ((elem_nxt == 3'd1) || (elem_nxt == 3'd3))
                     : ((elem_nxt == 3'd2) || (elem_nxt == 3'd4));
    acc_bg  = ((state == S_IDLE) ? bg_sel : bg) ? CHECKER : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      elem    <= 3'd0;
      addr    <= '0;
      phase   <= 1'b0;
      bg      <= 1'b0;
      ram_cen <= 1'b1;
      ram_wen <= 1'b1;
      ram_d   <= '0;
    end else begin
      state   <= state_nxt;
      elem    <= elem_nxt;
      addr    <= addr_nxt;
      phase   <= phase_nxt;
      if (start_acc) bg <= bg_sel;
      ram_cen <= !acc_run;
      ram_wen <= !(acc_run && acc_we);
      if (acc_run) ram_d <= acc_bg ^ {DW{acc_inv}};
    end
  end

  assign ram_a     = addr;
  assign bist_busy = (state == S_RUN) || (state == S_DRAIN);
  assign bist_done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Compare pipeline. On a read, ram_d already carries the expected word, so
  // it is captured as the reference for the data returning next cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_vld  <= 1'b0;
      exp_data <= '0;
      exp_addr <= '0;
      exp_elem <= 3'd0;
    end else begin
      exp_vld <= !ram_cen && ram_wen;
      if (!ram_cen && ram_wen) begin
        exp_data <= ram_d;
        exp_addr <= ram_a;
        exp_elem <= elem;
      end
    end
  end

  always_comb begin
    mism = '0;
    for (int c = 0; c < NCH; c++) begin
      mism[c] = exp_vld && (ram_q[c*DW +: DW] != exp_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      fail_ch   <= '0;
      fail_cnt  <= 16'd0;
    end else if (start_acc) begin
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      fail_ch   <= '0;
      fail_cnt  <= 16'd0;
    end else if (|mism) begin
      bist_fail <= 1'b1;
      if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      if (!bist_fail) begin
        fail_addr <= exp_addr;
        fail_elem <= exp_elem;
        fail_ch   <= mism;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with DEPTH=16, NCH=2, DW=32 and a
// behavioural two-channel RAM that can inject stuck-at bits on one word.
// Ports: drives every DUT port; cycle 0 is the cycle in which start is sampled.
module tb_sram_march_bist;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NCH   = 2;

  logic              clk;
  logic              rst_n;
  logic              bist_start;
  logic              bg_sel;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [AW-1:0]     fail_addr;
  logic [2:0]        fail_elem;
  logic [NCH-1:0]    fail_ch;
  logic [15:0]       fail_cnt;
  logic              ram_cen;
  logic              ram_wen;
  logic [AW-1:0]     ram_a;
  logic [DW-1:0]     ram_d;
  logic [NCH*DW-1:0] ram_q;

  sram_march_bist #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .bist_start(bist_start), .bg_sel(bg_sel),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_ch(fail_ch),
    .fail_cnt(fail_cnt), .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a single faulty word: read value = (cell | f_or) & ~f_clr.
  logic [DW-1:0] mem [NCH][DEPTH];
  logic          f_en;
  int            f_ch;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_or, f_clr;

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    if (!ram_cen) begin
      for (int c = 0; c < NCH; c++) begin
        if (!ram_wen) begin
          mem[c][ram_a] <= ram_d;
        end else begin
          rd = mem[c][ram_a];
          if (f_en && c == f_ch && ram_a == f_addr) rd = (rd | f_or) & ~f_clr;
          ram_q[c*DW +: DW] <= rd;
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle trace of the last run, indexed by cycle number.
  logic          tr_cen [512];
  logic          tr_wen [512];
  logic [AW-1:0] tr_a   [512];
  logic [DW-1:0] tr_d   [512];

  task automatic set_fault(input logic en, input int ch, input logic [AW-1:0] a,
                           input logic [DW-1:0] orm, input logic [DW-1:0] clrm);
    f_en = en; f_ch = ch; f_addr = a; f_or = orm; f_clr = clrm;
  endtask

  // One start pulse; samples every cycle at the falling edge until done.
  task automatic run_one(input logic bg, output int done_cyc, output int cen_cnt,
                         output int busy_cnt);
    int cyc;
    @(negedge clk);
    bg_sel     = bg;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    cyc = 1; done_cyc = -1; cen_cnt = 0; busy_cnt = 0;
    while (cyc < 400 && done_cyc < 0) begin
      tr_cen[cyc] = ram_cen;
      tr_wen[cyc] = ram_wen;
      tr_a[cyc]   = ram_a;
      tr_d[cyc]   = ram_d;
      if (!ram_cen) cen_cnt++;
      if (bist_busy) busy_cnt++;
      if (bist_done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bist_done}, 32'd0);
  endtask

  int done_cyc, cen_cnt, busy_cnt;
  int d1, d2, cyc, extra_done;

  initial begin
    rst_n = 1'b0; bist_start = 1'b0; bg_sel = 1'b0;
    set_fault(1'b0, 0, '0, '0, '0);
    #12;
    chk("rst_cen",  {31'd0, ram_cen},   32'd1);
    chk("rst_wen",  {31'd0, ram_wen},   32'd1);
    chk("rst_busy", {31'd0, bist_busy}, 32'd0);
    chk("rst_done", {31'd0, bist_done}, 32'd0);
    chk("rst_fail", {31'd0, bist_fail}, 32'd0);
    chk("rst_cnt",  {16'd0, fail_cnt},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean run, solid background.
    run_one(1'b0, done_cyc, cen_cnt, busy_cnt);
    chk("clean_done_cyc", done_cyc, 32'd162);
    chk("clean_cen_cnt",  cen_cnt,  32'd160);
    chk("clean_busy_cnt", busy_cnt, 32'd161);
    chk("clean_cen_c1",   {31'd0, tr_cen[1]},   32'd0);
    chk("clean_cen_c160", {31'd0, tr_cen[160]}, 32'd0);
    chk("clean_cen_drain",{31'd0, tr_cen[161]}, 32'd1);
    chk("clean_fail",     {31'd0, bist_fail},   32'd0);
    chk("clean_cnt",      {16'd0, fail_cnt},    32'd0);

    // Channel 1, address 5, bit 3 stuck-at-1: reads of B=0 in M1, M3, M5 fail.
    set_fault(1'b1, 1, 4'd5, 32'h8, 32'h0);
    run_one(1'b0, done_cyc, cen_cnt, busy_cnt);
    chk("sa1_done_cyc", done_cyc, 32'd162);
    chk("sa1_fail",     {31'd0, bist_fail}, 32'd1);
    chk("sa1_addr",     {28'd0, fail_addr}, 32'd5);
    chk("sa1_elem",     {29'd0, fail_elem}, 32'd1);
    chk("sa1_ch",       {30'd0, fail_ch},   32'd2);
    chk("sa1_cnt",      {16'd0, fail_cnt},  32'd3);

    // Checkerboard, clean: trace the write data and M3 address order.
    set_fault(1'b0, 0, '0, '0, '0);
    run_one(1'b1, done_cyc, cen_cnt, busy_cnt);
    chk("cb_fail_cleared", {31'd0, bist_fail}, 32'd0);
    chk("cb_m0_wen",   {31'd0, tr_wen[1]}, 32'd0);
    chk("cb_m0_d",     tr_d[1],  32'h5555_5555);
    chk("cb_m0_a15",   {28'd0, tr_a[16]}, 32'd15);
    chk("cb_m1_rd",    {31'd0, tr_wen[17]}, 32'd1);
    chk("cb_m1_wen",   {31'd0, tr_wen[18]}, 32'd0);
    chk("cb_m1_d",     tr_d[18], 32'hAAAA_AAAA);
    chk("cb_m1_a",     {28'd0, tr_a[18]}, 32'd0);
    chk("cb_m3_first", {28'd0, tr_a[81]}, 32'd15);
    chk("cb_m3_next",  {28'd0, tr_a[83]}, 32'd14);
    chk("cb_m3_last",  {28'd0, tr_a[111]}, 32'd0);
    chk("cb_m5_last",  {28'd0, tr_a[160]}, 32'd15);
    chk("cb_m5_rd",    {31'd0, tr_wen[160]}, 32'd1);
    chk("cb_cnt",      {16'd0, fail_cnt}, 32'd0);

    // Channel 0, address 0, all bits stuck-at-0: reads of ~B in M2, M4 fail.
    set_fault(1'b1, 0, 4'd0, 32'h0, 32'hFFFF_FFFF);
    run_one(1'b0, done_cyc, cen_cnt, busy_cnt);
    chk("sa0_cnt",  {16'd0, fail_cnt},  32'd2);
    chk("sa0_addr", {28'd0, fail_addr}, 32'd0);
    chk("sa0_elem", {29'd0, fail_elem}, 32'd2);
    chk("sa0_ch",   {30'd0, fail_ch},   32'd1);

    // Reset in the middle of a run.
    set_fault(1'b0, 0, '0, '0, '0);
    @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cen",  {31'd0, ram_cen},   32'd1);
    chk("mid_rst_wen",  {31'd0, ram_wen},   32'd1);
    chk("mid_rst_busy", {31'd0, bist_busy}, 32'd0);
    chk("mid_rst_fail", {31'd0, bist_fail}, 32'd0);
    chk("mid_rst_cnt",  {16'd0, fail_cnt},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bist_done || bist_busy) extra_done++;
    end
    chk("mid_rst_no_done", extra_done, 32'd0);
    run_one(1'b0, done_cyc, cen_cnt, busy_cnt);
    chk("after_rst_done_cyc", done_cyc, 32'd162);
    chk("after_rst_cen_cnt",  cen_cnt,  32'd160);

    // Start held high: back-to-back runs, fail cleared at each restart.
    set_fault(1'b1, 1, 4'd5, 32'h8, 32'h0);
    @(negedge clk);
    bg_sel = 1'b0;
    bist_start = 1'b1;
    cyc = 0; d1 = -1; d2 = -1;
    while (cyc < 700 && d2 < 0) begin
      @(negedge clk);
      cyc++;
      if (bist_done) begin
        if (d1 < 0) begin
          d1 = cyc;
          chk("hold_fail_run1", {31'd0, bist_fail}, 32'd1);
        end else begin
          d2 = cyc;
          chk("hold_fail_run2", {31'd0, bist_fail}, 32'd1);
        end
      end
      if (d1 >= 0 && cyc == d1 + 2) begin
        chk("hold_fail_cleared", {31'd0, bist_fail}, 32'd0);
        chk("hold_busy_restart", {31'd0, bist_busy}, 32'd1);
      end
    end
    bist_start = 1'b0;
    chk("hold_first_done", d1, 32'd162);
    chk("hold_spacing",    d2 - d1, 32'd163);
    repeat (4) @(negedge clk);
    chk("hold_stopped", {31'd0, bist_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Parametrised March C- built-in self-test engine for the SMIC40 single-port SRAM wrappers. It drives NCH identical RAM instances in lockstep and compares every read against the expected data background. It records the first failing address, element and channel mask, plus a saturating fail count. It sits between the SoC test controller (start/status) and the RAM wrappers' native ports. Functional traffic is muxed in outside this block.

## Interface
- DW, 32, data width per RAM channel
- AW, 10, address width
- DEPTH, 1024, words tested; addresses 0..DEPTH-1, DEPTH ≤ 2^AW, DEPTH ≥ 2
- NCH, 1, number of RAM channels tested in parallel (1..8)

- clk  in  1  single clock for block and RAMs
- rst_n  in  1  asynchronous, active-low reset
- bist_start  in  1  level; sampled only in IDLE
- bg_sel  in  1  data background: 0 = solid (0/all-ones), 1 = checkerboard (0x55../0xAA..); sampled with bist_start
- bist_busy  out  1  high from the cycle after start acceptance until done
- bist_done  out  1  one-cycle pulse at end of test
- bist_fail  out  1  sticky; set on any miscompare, cleared on next accepted start
- fail_addr  out  AW  address of first miscompare
- fail_elem  out  3  March element (0..5) of first miscompare
- fail_ch  out  NCH  per-channel miscompare mask at first miscompare
- fail_cnt  out  16  miscompare count (one per failing read cycle, any channel), saturates at 0xFFFF
- ram_cen  out  1  chip enable, active low
- ram_wen  out  1  write enable, active low
- ram_a  out  AW  address, shared by all channels
- ram_d  out  DW  write data, shared by all channels
- ram_q  in  NCH*DW  read data, channel c at [c*DW +: DW]; valid one cycle after read

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: ram_cen=1. If bist_start=1:
  - latch bg_sel;
  - clear bist_fail, fail_addr, fail_elem, fail_ch, fail_cnt;
  - go to RUN with elem=0, addr=0, phase=0.
- RUN executes the March C- elements, with B = background word and ~B = its complement:
  - M0 ⇕ w(B), ascending
  - M1 ⇑ r(B), w(~B)
  - M2 ⇑ r(~B), w(B)
  - M3 ⇓ r(B), w(~B)
  - M4 ⇓ r(~B), w(B)
  - M5 ⇕ r(B), ascending
- Per address in M0 and M5: one cycle. In M1–M4: phase 0 reads, phase 1 writes the same address.
- Ascending elements run addr 0→DEPTH-1; descending run DEPTH-1→0. Element changes on the last address; the next element starts at its own first address in the following cycle, with no gap.
- After the last M5 read, go to DRAIN for 1 cycle (compare of final read), then DONE for 1 cycle (bist_done=1), then IDLE.
- Compare pipeline:
  - Each read registers exp_data, exp_addr, exp_elem and a valid bit; the compare happens in the next cycle against ram_q.
  - Per channel: mismatch if ram_q slice ≠ exp_data.
  - Any mismatch: fail_cnt+1 (saturating) and bist_fail=1. On the first miscompare only, capture fail_addr, fail_elem and the mismatch vector into fail_ch.
- bist_start held high through DONE restarts the test from IDLE on the next cycle; a new start is never accepted outside IDLE.
- Checkerboard B = {DW/2{2'b01}}; DW must be even.

## Timing
- Reset values: every output 0, except ram_cen=1 and ram_wen=1. All internal state returns to IDLE.
- Cycle 0: start sampled in IDLE.
- Cycles 1..10·DEPTH: RAM accesses, with ram_cen=0 every cycle. bist_busy=1 from cycle 1 through cycle 10·DEPTH+1.
- Cycle 10·DEPTH+1: DRAIN, ram_cen=1.
- Cycle 10·DEPTH+2: bist_done=1, bist_busy=0. Fail outputs are final and stay stable until the next start.
- ram_wen=0 exactly on write cycles. ram_d is don't-care on reads and driven with B/~B on writes. All RAM outputs are registered.
- Reset asserted mid-test: RAM outputs go idle immediately (async), no done pulse is produced, and the results are cleared.

## Test plan
- DEPTH=16, NCH=2, clean RAM models, bg_sel=0, start pulse → 160 consecutive ram_cen=0 cycles; bist_done at cycle 162; bist_fail=0; fail_cnt=0.
- Same setup, channel 1 bit 3 stuck-at-1 at address 5 → first fail in M0-read-free region detected at M1; fail_addr=5, fail_elem=1, fail_ch=2'b10; fail_cnt=3 (the M1, M3 and M5 reads of B).
- bg_sel=1, DW=32, check ram_d trace → M0 writes 0x55555555, M1 writes 0xAAAAAAAA; M3 addresses run 15→0.
- Channel 0 address 0 stuck-at-0 on all bits → fail_cnt=2 (M2 and M4 reads of ~B); fail_addr=0, fail_elem=2.
- rst_n pulsed low at cycle 50 of a run → immediately ram_cen=1, bist_busy=0, no bist_done; a new start afterwards completes normally in 162 cycles.
- bist_start held high continuously → back-to-back tests with bist_done pulses exactly 163 cycles apart; bist_fail cleared at each restart.
